// File: rtl/clock_time_ctrl.sv
// BCD hh:mm:ss timekeeper with a RUN/SET_HOUR/SET_MIN button FSM.
// Leaving set mode restarts the external second-tick generator to phase-align seconds.
module clock_time_ctrl #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick_clr,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    state_t state;

    // Two-digit BCD increment that wraps to 00 after the given last value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign mode = state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= RUN;
            hour_bcd  <= 8'h00;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            blink     <= 1'b0;
            day_pulse <= 1'b0;
            tick_clr  <= 1'b1;
        end else begin
            day_pulse <= 1'b0;
            tick_clr  <= 1'b0;
            case (state)
                RUN: begin
                    if (tick) begin
                        sec_bcd <= bcd_inc(sec_bcd, 8'h59);
                        if (sec_bcd == 8'h59) begin
                            min_bcd <= bcd_inc(min_bcd, 8'h59);
                            if (min_bcd == 8'h59) begin
                                hour_bcd <= bcd_inc(hour_bcd, HOUR_MAX_BCD);
                                if (hour_bcd == HOUR_MAX_BCD)
                                    day_pulse <= 1'b1;
                            end
                        end
                    end
                    if (mode_btn) begin
                        state <= SET_HOUR;
                        blink <= 1'b1;
                    end
                end
                SET_HOUR: begin
                    if (mode_btn) begin
                        state <= SET_MIN;
                        blink <= 1'b1;
                    end else begin
                        if (inc_btn)
                            hour_bcd <= bcd_inc(hour_bcd, HOUR_MAX_BCD);
                        if (tick)
                            blink <= ~blink;
                    end
                end
                SET_MIN: begin
                    // Confirming the time zeroes seconds and drops any coincident tick.
                    if (mode_btn) begin
                        state    <= RUN;
                        sec_bcd  <= 8'h00;
                        blink    <= 1'b0;
                        tick_clr <= 1'b1;
                    end else begin
                        if (inc_btn)
                            min_bcd <= bcd_inc(min_bcd, 8'h59);
                        if (tick)
                            blink <= ~blink;
                    end
                end
                default: begin
                    state <= RUN;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: a vector table plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time.
module tb_clock_time_ctrl;

    typedef struct {
        logic       clr;
        logic       tick;
        logic       mb;
        logic       ib;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bl;
        logic       tc;
        logic       dp;
        bit         sel;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1, tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink, tick_clr, day_pulse;

    logic       clr11 = 1'b1, tick11 = 1'b0, mode_btn11 = 1'b0, inc_btn11 = 1'b0;
    logic [7:0] hour11, min11, sec11;
    logic [1:0] mode11;
    logic       blink11, tick_clr11, day_pulse11;

    clock_time_ctrl #(.HOUR_MAX(23)) dut (
        .clk(clk), .clr(clr), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode),
        .blink(blink), .tick_clr(tick_clr), .day_pulse(day_pulse)
    );

    clock_time_ctrl #(.HOUR_MAX(11)) dut11 (
        .clk(clk), .clr(clr11), .tick(tick11), .mode_btn(mode_btn11), .inc_btn(inc_btn11),
        .hour_bcd(hour11), .min_bcd(min11), .sec_bcd(sec11), .mode(mode11),
        .blink(blink11), .tick_clr(tick_clr11), .day_pulse(day_pulse11)
    );

    vec_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic vec_t mk(input bit sel, input logic c, input logic t, input logic mb,
                                input logic ib, input logic [7:0] h, input logic [7:0] m,
                                input logic [7:0] s, input logic [1:0] md, input logic bl,
                                input logic tc, input logic dp);
        vec_t v;
        v.sel = sel; v.clr = c; v.tick = t; v.mb = mb; v.ib = ib;
        v.h = h; v.m = m; v.s = s; v.md = md; v.bl = bl; v.tc = tc; v.dp = dp;
        return v;
    endfunction

    task automatic setInputs(input bit sel, input logic c, input logic t, input logic mb,
                             input logic ib);
        if (sel) begin
            clr11 = c; tick11 = t; mode_btn11 = mb; inc_btn11 = ib;
        end else begin
            clr = c; tick = t; mode_btn = mb; inc_btn = ib;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        setInputs(v.sel, v.clr, v.tick, v.mb, v.ib);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t        e;
        logic [28:0] act, want;
        @(posedge clk);
        #1;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no expected entry queued", tag);
        end else begin
            e = exp_q.pop_front();
            if (e.sel)
                act = {hour11, min11, sec11, mode11, blink11, tick_clr11, day_pulse11};
            else
                act = {hour_bcd, min_bcd, sec_bcd, mode, blink, tick_clr, day_pulse};
            want = {e.h, e.m, e.s, e.md, e.bl, e.tc, e.dp};
            if (act !== want) begin
                tests_failed++;
                $display("[TB] FAIL %s: got %h:%h:%h mode=%b blink=%b tick_clr=%b day=%b, want %h:%h:%h mode=%b blink=%b tick_clr=%b day=%b",
                         tag, act[28:21], act[20:13], act[12:5], act[4:3], act[2], act[1], act[0],
                         e.h, e.m, e.s, e.md, e.bl, e.tc, e.dp);
            end
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag);
    endtask

    // Unchecked cycles used to walk the counters to a preload value.
    task automatic drive(input bit sel, input int n, input logic t, input logic mb, input logic ib);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            setInputs(sel, 1'b0, t, mb, ib);
            @(posedge clk);
        end
    endtask

    vec_t table_v[17];

    initial begin
        table_v[0]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0);
        table_v[1]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0);
        table_v[2]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0);
        table_v[3]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0);
        table_v[4]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'd0, 0, 0, 0);
        table_v[5]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h02, 2'd0, 0, 0, 0);
        table_v[6]  = mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h02, 2'd1, 1, 0, 0);
        table_v[7]  = mk(0, 0, 0, 0, 1, 8'h01, 8'h00, 8'h02, 2'd1, 1, 0, 0);
        table_v[8]  = mk(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h02, 2'd1, 0, 0, 0);
        table_v[9]  = mk(0, 0, 0, 1, 1, 8'h01, 8'h00, 8'h02, 2'd2, 1, 0, 0);
        table_v[10] = mk(0, 0, 0, 0, 1, 8'h01, 8'h01, 8'h02, 2'd2, 1, 0, 0);
        table_v[11] = mk(0, 0, 1, 1, 0, 8'h01, 8'h01, 8'h00, 2'd0, 0, 1, 0);
        table_v[12] = mk(0, 0, 0, 0, 0, 8'h01, 8'h01, 8'h00, 2'd0, 0, 0, 0);
        table_v[13] = mk(0, 0, 1, 1, 0, 8'h01, 8'h01, 8'h01, 2'd1, 1, 0, 0);
        table_v[14] = mk(0, 0, 0, 1, 0, 8'h01, 8'h01, 8'h01, 2'd2, 1, 0, 0);
        table_v[15] = mk(0, 0, 0, 1, 0, 8'h01, 8'h01, 8'h00, 2'd0, 0, 1, 0);
        table_v[16] = mk(0, 0, 0, 0, 1, 8'h01, 8'h01, 8'h00, 2'd0, 0, 0, 0);

        for (int i = 0; i < 17; i++)
            step($sformatf("table[%0d]", i), table_v[i]);

        // Preload 23:59:58 through set mode and roll over the day.
        step("day_clr",   mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0));
        step("day_seth",  mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0));
        drive(0, 23, 0, 0, 1);
        step("day_setm",  mk(0, 0, 0, 1, 0, 8'h23, 8'h00, 8'h00, 2'd2, 1, 0, 0));
        drive(0, 59, 0, 0, 1);
        step("day_run",   mk(0, 0, 0, 1, 0, 8'h23, 8'h59, 8'h00, 2'd0, 0, 1, 0));
        drive(0, 57, 1, 0, 0);
        step("day_58",    mk(0, 0, 1, 0, 0, 8'h23, 8'h59, 8'h58, 2'd0, 0, 0, 0));
        step("day_59",    mk(0, 0, 1, 0, 0, 8'h23, 8'h59, 8'h59, 2'd0, 0, 0, 0));
        step("day_wrap",  mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 1));
        step("day_after", mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0));

        // Hour setting wraps without carrying; ticks only toggle blink.
        step("sh_tick",   mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'd0, 0, 0, 0));
        step("sh_enter",  mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h02, 2'd1, 1, 0, 0));
        drive(0, 21, 0, 0, 1);
        step("sh_22",     mk(0, 0, 0, 0, 1, 8'h22, 8'h00, 8'h02, 2'd1, 1, 0, 0));
        step("sh_23",     mk(0, 0, 0, 0, 1, 8'h23, 8'h00, 8'h02, 2'd1, 1, 0, 0));
        step("sh_00",     mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h02, 2'd1, 1, 0, 0));
        step("sh_01",     mk(0, 0, 0, 0, 1, 8'h01, 8'h00, 8'h02, 2'd1, 1, 0, 0));
        step("sh_blink0", mk(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h02, 2'd1, 0, 0, 0));
        step("sh_blink1", mk(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h02, 2'd1, 1, 0, 0));

        // Minute setting from 58 with seconds at 37, then confirm.
        step("sm_clr",    mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0));
        drive(0, 36, 1, 0, 0);
        step("sm_s37",    mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h37, 2'd0, 0, 0, 0));
        step("sm_seth",   mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h37, 2'd1, 1, 0, 0));
        step("sm_h01",    mk(0, 0, 0, 0, 1, 8'h01, 8'h00, 8'h37, 2'd1, 1, 0, 0));
        step("sm_setm",   mk(0, 0, 0, 1, 0, 8'h01, 8'h00, 8'h37, 2'd2, 1, 0, 0));
        drive(0, 57, 0, 0, 1);
        step("sm_58",     mk(0, 0, 0, 0, 1, 8'h01, 8'h58, 8'h37, 2'd2, 1, 0, 0));
        step("sm_59",     mk(0, 0, 0, 0, 1, 8'h01, 8'h59, 8'h37, 2'd2, 1, 0, 0));
        step("sm_00",     mk(0, 0, 0, 0, 1, 8'h01, 8'h00, 8'h37, 2'd2, 1, 0, 0));
        step("sm_run",    mk(0, 0, 0, 1, 0, 8'h01, 8'h00, 8'h00, 2'd0, 0, 1, 0));
        step("sm_tclr0",  mk(0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'd0, 0, 0, 0));

        // HOUR_MAX=11 instance: day wrap at 11:59:59 and reset from SET_MIN.
        step("h11_clr",   mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0));
        step("h11_seth",  mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0));
        drive(1, 11, 0, 0, 1);
        step("h11_hwrap", mk(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0));
        drive(1, 11, 0, 0, 1);
        step("h11_setm",  mk(1, 0, 0, 1, 0, 8'h11, 8'h00, 8'h00, 2'd2, 1, 0, 0));
        drive(1, 59, 0, 0, 1);
        step("h11_run",   mk(1, 0, 0, 1, 0, 8'h11, 8'h59, 8'h00, 2'd0, 0, 1, 0));
        drive(1, 58, 1, 0, 0);
        step("h11_59",    mk(1, 0, 1, 0, 0, 8'h11, 8'h59, 8'h59, 2'd0, 0, 0, 0));
        step("h11_wrap",  mk(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 1));
        step("h11_after", mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0));
        step("h11_tick",  mk(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'd0, 0, 0, 0));
        step("h11_m1",    mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 2'd1, 1, 0, 0));
        step("h11_m2",    mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 2'd2, 1, 0, 0));
        step("h11_inc",   mk(1, 0, 0, 0, 1, 8'h00, 8'h01, 8'h01, 2'd2, 1, 0, 0));
        step("h11_midclr",mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0));
        step("h11_rel",   mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping and set-mode controller for the digital clock. It consumes the one-cycle-per-second pulse from the 100 MHz second-tick generator and advances a BCD hh:mm:ss register set. A mode/increment button FSM lets the user set hours and minutes. On leaving set mode it restarts the tick generator so that seconds are phase-aligned to the moment the user confirms.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 0 (binary integer; 23 for 24 h display, 11 for 0–11 display); legal range 1..23

Ports:
clk  in  1  system clock (100 MHz)
clr  in  1  synchronous active-high reset
tick  in  1  one-cycle pulse, once per second, from the tick generator
mode_btn  in  1  debounced single-cycle pulse; cycles RUN -> SET_HOUR -> SET_MIN -> RUN
inc_btn  in  1  debounced single-cycle pulse; increments the field being set
hour_bcd  out  8  hours, BCD: [7:4] tens, [3:0] units
min_bcd  out  8  minutes, BCD
sec_bcd  out  8  seconds, BCD
mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven
blink  out  1  display blink enable for the field being set; always 0 in RUN
tick_clr  out  1  one-cycle restart pulse to the tick generator's clr input
day_pulse  out  1  one-cycle pulse on the wrap from HOUR_MAX:59:59 to 00:00:00

Behaviour:
- clk and reset: single clk domain. clr is sampled on the rising edge of clk. The reset is synchronous and active-high.
- Reset values while clr=1: all time fields 00, mode=RUN, blink=0, day_pulse=0, tick_clr=1.
  - tick_clr is held high during reset so the tick generator is reset together with this block.
- Outputs: all are registered. An input sampled high at edge N is reflected in the outputs after edge N. Latency is 1 cycle.
- Time fields are held internally in BCD. Digit-wise increment rules:
  - Units 9 -> 0 carries into tens.
  - sec/min wrap 59 -> 00.
  - hour wraps HOUR_MAX -> 00.
  - No field ever holds an invalid BCD digit or an out-of-range value.
- RUN state:
  - tick=1: sec+1. On sec 59->00, min+1. On min 59->00, hour+1.
  - On the full HOUR_MAX:59:59 wrap: day_pulse=1 for one cycle.
  - inc_btn is ignored.
- SET_HOUR state:
  - inc_btn=1: hour+1 with wrap; no carry out.
  - tick does not change time; it toggles blink.
- SET_MIN state:
  - inc_btn=1: min+1 with wrap; no carry into hour.
  - tick toggles blink.
- FSM transitions on mode_btn=1:
  - RUN->SET_HOUR: sec is left unchanged; blink is set to 1.
  - SET_HOUR->SET_MIN: blink is set to 1.
  - SET_MIN->RUN: sec is set to 00, blink is set to 0, and tick_clr=1 for exactly one cycle.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: the mode transition wins and inc is dropped.
  - tick with mode_btn on SET_MIN->RUN: the tick is dropped and sec=00.
  - tick with mode_btn on RUN->SET_HOUR: the tick is applied and the transition is also taken.
- tick_clr: asserted only in reset and on SET_MIN->RUN; 0 at all other times.
- Reset mid-set: clr in any state returns the block to RUN at 00:00:00; the partially set values are lost.

Test Plan:
1. Assert clr for 3 cycles, then release. Outputs 00:00:00, mode=00, blink=0. tick_clr=1 during reset and 0 on the first cycle after.
2. RUN with time preloaded by set mode to 23:59:58, then 2 tick pulses:
   - After the first tick: 23:59:59.
   - After the second tick: 00:00:00, with day_pulse=1 for exactly that one cycle.
3. Enter SET_HOUR at hour 22, then 3 inc_btn pulses:
   - hour goes 23, 00, 01.
   - min and sec are unchanged, and hour does not carry anywhere.
   - 2 tick pulses toggle blink 1->0->1 with time unchanged.
4. SET_MIN at min 58 with sec=37, then 2 inc_btn pulses:
   - min goes 59, then 00; hour is unchanged.
   - Then mode_btn: mode=RUN, sec=00, tick_clr high for exactly 1 cycle, blink=0.
5. In SET_HOUR, drive mode_btn and inc_btn in the same cycle: mode becomes SET_MIN and hour is unchanged.
   - In SET_MIN, drive tick and mode_btn in the same cycle: RUN with sec=00.
6. Parameter run with HOUR_MAX=11 from 11:59:59, then tick: 00:00:00 with day_pulse=1. Also assert clr while in SET_MIN: RUN at 00:00:00.
